// File: rtl/muldiv_unit_if.sv
// Issue/writeback bundle between the operand read stage and the iterative
// multiply/divide unit.
interface muldiv_unit_if #(parameter int WIDTH = 16);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src1_val;
  logic [WIDTH-1:0] src2_val;
  logic [2:0]       tgt_in;
  logic             busy;
  logic             done;
  logic             we_reg;
  logic [2:0]       tgt;
  logic [WIDTH-1:0] write_data;

  modport master (
    output start, op, src1_val, src2_val, tgt_in,
    input  busy, done, we_reg, tgt, write_data
  );

  modport slave (
    input  start, op, src1_val, src2_val, tgt_in,
    output busy, done, we_reg, tgt, write_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply / divide: one result bit per cycle, shift-add
// multiply and restoring divide sharing one {hi, lo} register pair.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | iterating, counter 15 down to 0, busy high
// DONE  | result valid for one cycle (done/we_reg), may accept next op
module muldiv_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [2:0]       tgt_q;

  logic             busy_q;
  logic             done_q;
  logic             we_q;
  logic [2:0]       tgt_out_q;
  logic [WIDTH-1:0] wdata_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic             sub_ok;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;

  // hi holds accumulator / partial remainder, lo holds multiplier / quotient;
  // opb is the multiplicand for MUL and the divisor for DIV.
  always_comb begin
    sum     = {1'b0, hi_q} + {1'b0, opb_q};
    shifted = {hi_q, lo_q[WIDTH-1]};
    sub_ok  = (shifted >= {1'b0, opb_q});
    hi_nxt  = hi_q;
    lo_nxt  = lo_q;
    if (!op_q[1]) begin
      if (lo_q[0]) {hi_nxt, lo_nxt} = {sum, lo_q[WIDTH-1:1]};
      else         {hi_nxt, lo_nxt} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
    end else begin
      // A successful trial leaves a remainder below the divisor, so the
      // 16-bit wrapped difference is exact.
      if (sub_ok) hi_nxt = shifted[WIDTH-1:0] - opb_q;
      else        hi_nxt = shifted[WIDTH-1:0];
      lo_nxt = {lo_q[WIDTH-2:0], sub_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      tgt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      tgt_out_q <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        RUN: begin
          hi_q <= hi_nxt;
          lo_q <= lo_nxt;
          if (cnt == '0) begin
            state     <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            we_q      <= 1'b1;
            tgt_out_q <= tgt_q;
            wdata_q   <= op_q[0] ? hi_nxt : lo_nxt;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          done_q <= 1'b0;
          we_q   <= 1'b0;
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
            cnt    <= '1;
            op_q   <= bus.op;
            opb_q  <= bus.op[1] ? bus.src2_val : bus.src1_val;
            lo_q   <= bus.op[1] ? bus.src1_val : bus.src2_val;
            hi_q   <= '0;
            tgt_q  <= bus.tgt_in;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.we_reg     = we_q;
  assign bus.tgt        = tgt_out_q;
  assign bus.write_data = wdata_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results are queued at issue and
// compared when done pulses.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_unit_if bus ();
  muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [15:0] data;
    logic [2:0]  tgt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'h0, a} * {16'h0, b};
    case (o)
      2'b00:   return p[15:0];
      2'b01:   return p[31:16];
      2'b10:   return (b == 16'h0) ? 16'hFFFF : a / b;
      default: return (b == 16'h0) ? a : a % b;
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input logic [2:0] t);
    exp_t e;
    bus.op = o; bus.src1_val = a; bus.src2_val = b; bus.tgt_in = t;
    bus.start = 1'b1;
    e.data = model(o, a, b);
    e.tgt  = t;
    exp_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done; optionally scrambles inputs while waiting.
  task automatic wait_done(input bit wiggle, output int cyc, output int busy_cnt, output bit found);
    cyc = 0; busy_cnt = 0; found = 1'b0;
    while (cyc < 40 && !found) begin
      if (bus.done === 1'b1) found = 1'b1;
      else begin
        if (bus.busy === 1'b1) busy_cnt++;
        cyc++;
        if (wiggle) begin
          bus.start    = 1'($urandom_range(0, 1));
          bus.op       = 2'($urandom_range(0, 3));
          bus.src1_val = 16'($urandom);
          bus.src2_val = 16'($urandom);
          bus.tgt_in   = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.src1_val = 16'h0; bus.src2_val = 16'h0; bus.tgt_in = 3'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.we_reg !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", bus.we_reg); end
    total++; if (bus.tgt !== 3'd0) begin bad++; $display("FAIL reset_tgt got=%0d want=0", bus.tgt); end
    total++; if (bus.write_data !== 16'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0000", bus.write_data); end
    @(negedge clk);
  endtask

  // Runs a table of single operations, each checked for latency, busy length,
  // result, target and single-cycle done.
  task automatic run_table(input string name, input logic [1:0] ops[], input logic [15:0] as[],
                           input logic [15:0] bs[], input logic [2:0] ts[]);
    int cyc, bc; bit found; exp_t e;
    for (int i = 0; i < ops.size(); i++) begin
      issue(ops[i], as[i], bs[i], ts[i]);
      wait_done(1'b0, cyc, bc, found);
      total++; if (!found) begin bad++; $display("FAIL %s[%0d]_timeout got=no_done want=done", name, i); continue; end
      e = exp_q.pop_front();
      total++; if (cyc !== 16) begin bad++; $display("FAIL %s[%0d]_latency got=%0d want=16", name, i, cyc); end
      total++; if (bc !== 16) begin bad++; $display("FAIL %s[%0d]_busy_cycles got=%0d want=16", name, i, bc); end
      total++; if (bus.we_reg !== 1'b1) begin bad++; $display("FAIL %s[%0d]_we got=%b want=1", name, i, bus.we_reg); end
      total++; if (bus.write_data !== e.data) begin bad++; $display("FAIL %s[%0d]_data got=%h want=%h", name, i, bus.write_data, e.data); end
      total++; if (bus.tgt !== e.tgt) begin bad++; $display("FAIL %s[%0d]_tgt got=%0d want=%0d", name, i, bus.tgt, e.tgt); end
      @(negedge clk);
      total++; if (bus.done !== 1'b0 || bus.we_reg !== 1'b0) begin bad++; $display("FAIL %s[%0d]_pulse got=%b%b want=00", name, i, bus.done, bus.we_reg); end
      total++; if (bus.write_data !== e.data) begin bad++; $display("FAIL %s[%0d]_hold got=%h want=%h", name, i, bus.write_data, e.data); end
    end
  endtask

  task automatic test_mul;
    run_table("mul", '{2'b00, 2'b00, 2'b01, 2'b01}, '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h1234},
              '{16'h0010, 16'hFFFF, 16'hFFFF, 16'h5678}, '{3'd3, 3'd1, 3'd2, 3'd0});
  endtask

  task automatic test_div;
    run_table("div", '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10}, '{16'd100, 16'd100, 16'h1234, 16'h1234, 16'hBEEF},
              '{16'd7, 16'd7, 16'h0000, 16'h0000, 16'h00FF}, '{3'd4, 3'd5, 3'd6, 3'd7, 3'd1});
  endtask

  task automatic test_ignore_start;
    int cyc, bc, extra; bit found; exp_t e;
    issue(2'b00, 16'h0321, 16'h0045, 3'd5);
    wait_done(1'b1, cyc, bc, found);
    total++; if (!found) begin bad++; $display("FAIL ignore_timeout got=no_done want=done"); end
    else begin
      e = exp_q.pop_front();
      total++; if (cyc !== 16) begin bad++; $display("FAIL ignore_latency got=%0d want=16", cyc); end
      total++; if (bus.write_data !== e.data) begin bad++; $display("FAIL ignore_data got=%h want=%h", bus.write_data, e.data); end
      total++; if (bus.tgt !== e.tgt) begin bad++; $display("FAIL ignore_tgt got=%0d want=%0d", bus.tgt, e.tgt); end
    end
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL ignore_extra_activity got=%0d want=0", extra); end
  endtask

  task automatic test_back_to_back;
    int cyc, bc; bit found; exp_t e;
    issue(2'b10, 16'd100, 16'd7, 3'd1);
    wait_done(1'b0, cyc, bc, found);
    total++; if (!found) begin bad++; $display("FAIL b2b_first_timeout got=no_done want=done"); end
    else begin
      e = exp_q.pop_front();
      total++; if (bus.write_data !== e.data) begin bad++; $display("FAIL b2b_first_data got=%h want=%h", bus.write_data, e.data); end
    end
    issue(2'b10, 16'hFFFF, 16'h0003, 3'd2);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL b2b_first_pulse got=%b want=0", bus.done); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_busy got=%b want=1", bus.busy); end
    wait_done(1'b0, cyc, bc, found);
    total++; if (!found) begin bad++; $display("FAIL b2b_second_timeout got=no_done want=done"); end
    else begin
      e = exp_q.pop_front();
      total++; if (cyc !== 16) begin bad++; $display("FAIL b2b_latency got=%0d want=16", cyc); end
      total++; if (bus.write_data !== e.data) begin bad++; $display("FAIL b2b_second_data got=%h want=%h", bus.write_data, e.data); end
      total++; if (bus.tgt !== e.tgt) begin bad++; $display("FAIL b2b_second_tgt got=%0d want=%0d", bus.tgt, e.tgt); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int cyc, bc, extra; bit found; exp_t e;
    issue(2'b00, 16'h00FF, 16'h0101, 3'd6);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0 || bus.we_reg !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b%b want=00", bus.done, bus.we_reg); end
    total++; if (bus.tgt !== 3'd0) begin bad++; $display("FAIL rstmid_tgt got=%0d want=0", bus.tgt); end
    total++; if (bus.write_data !== 16'h0) begin bad++; $display("FAIL rstmid_wdata got=%h want=0000", bus.write_data); end
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.we_reg === 1'b1) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL rstmid_stray_done got=%0d want=0", extra); end
    issue(2'b01, 16'hABCD, 16'h1234, 3'd7);
    wait_done(1'b0, cyc, bc, found);
    total++; if (!found) begin bad++; $display("FAIL rstmid_fresh_timeout got=no_done want=done"); end
    else begin
      e = exp_q.pop_front();
      total++; if (cyc !== 16) begin bad++; $display("FAIL rstmid_fresh_latency got=%0d want=16", cyc); end
      total++; if (bus.write_data !== e.data) begin bad++; $display("FAIL rstmid_fresh_data got=%h want=%h", bus.write_data, e.data); end
      total++; if (bus.tgt !== e.tgt) begin bad++; $display("FAIL rstmid_fresh_tgt got=%0d want=%0d", bus.tgt, e.tgt); end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
